// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and default widths for the memory arbiter.
// Optional round-robin arbitration is enabled with MEM_ARB_RR_EN.
package mem_arb_pkg;

    localparam int MEM_ARB_ADDR_W = 32;
    localparam int MEM_ARB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_t;

    typedef enum logic {
        OWN_IFU,
        OWN_LSU
    } owner_t;

endpackage

// File: rtl/mem_arb_grant.sv
// mem_arb_grant: picks IFU or LSU while the arbiter is idle.
// MEM_ARB_RR_EN selects round-robin; otherwise the LSU has fixed priority.
module mem_arb_grant
    import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
    input  logic clock,
    input  logic reset,
`endif
    input  logic i_idle,
    input  logic i_ifu_valid,
    input  logic i_lsu_valid,
    output logic o_gnt_ifu,
    output logic o_gnt_lsu
);

`ifdef MEM_ARB_RR_EN
    owner_t r_ptr;

    // Pointer names the preferred requester; flips after every grant.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ptr <= OWN_IFU;
        end else if (o_gnt_ifu) begin
            r_ptr <= OWN_LSU;
        end else if (o_gnt_lsu) begin
            r_ptr <= OWN_IFU;
        end
    end

    // On a tie the pointer holder wins.
    always_comb begin
        o_gnt_lsu = i_idle & i_lsu_valid
                  & (~i_ifu_valid | (r_ptr == OWN_LSU));
        o_gnt_ifu = i_idle & i_ifu_valid
                  & (~i_lsu_valid | (r_ptr == OWN_IFU));
    end
`else
    // LSU always wins a tie; IFU stalls behind it.
    always_comb begin
        o_gnt_lsu = i_idle & i_lsu_valid;
        o_gnt_ifu = i_idle & i_ifu_valid & ~i_lsu_valid;
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between IFU and LSU, one
// transaction in flight. Build with MEM_ARB_RR_EN for round-robin.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = MEM_ARB_ADDR_W,
    parameter int DATA_W = MEM_ARB_DATA_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_resp_valid,
    output logic [DATA_W-1:0]   ifu_rdata,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_resp_valid,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int MASK_W = DATA_W / 8;

    state_t              r_state;
    state_t              w_next;
    owner_t              r_owner;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_wen;
    logic [DATA_W-1:0]   r_wdata;
    logic [MASK_W-1:0]   r_wmask;
    logic [DATA_W-1:0]   r_ifu_rdata;
    logic [DATA_W-1:0]   r_lsu_rdata;
    logic                r_ifu_resp;
    logic                r_lsu_resp;
    logic                w_idle;
    logic                w_resp;
    logic                w_gnt_ifu;
    logic                w_gnt_lsu;

    assign w_idle = (r_state == IDLE);
    assign w_resp = (r_state == WAIT) & mem_resp_valid;

    mem_arb_grant u_grant (
`ifdef MEM_ARB_RR_EN
        .clock       (clock),
        .reset       (reset),
`endif
        .i_idle      (w_idle),
        .i_ifu_valid (ifu_req_valid),
        .i_lsu_valid (lsu_req_valid),
        .o_gnt_ifu   (w_gnt_ifu),
        .o_gnt_lsu   (w_gnt_lsu)
    );

    assign ifu_req_ready  = w_gnt_ifu;
    assign lsu_req_ready  = w_gnt_lsu;
    assign mem_req_valid  = (r_state == REQ);
    assign mem_addr       = r_addr;
    assign mem_wen        = r_wen;
    assign mem_wdata      = r_wdata;
    assign mem_wmask      = r_wmask;
    assign ifu_resp_valid = r_ifu_resp;
    assign lsu_resp_valid = r_lsu_resp;
    assign ifu_rdata      = r_ifu_rdata;
    assign lsu_rdata      = r_lsu_rdata;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state: grant -> issue -> wait for the single response.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (w_gnt_ifu | w_gnt_lsu) w_next = REQ;
            REQ:  if (mem_req_ready)         w_next = WAIT;
            WAIT: if (mem_resp_valid)        w_next = IDLE;
            default:                         w_next = IDLE;
        endcase
    end

    // Latch the granted request; IFU is always a plain read.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_owner <= OWN_IFU;
            r_addr  <= '0;
            r_wen   <= 1'b0;
            r_wdata <= '0;
            r_wmask <= '0;
        end else if (w_gnt_lsu) begin
            r_owner <= OWN_LSU;
            r_addr  <= lsu_addr;
            r_wen   <= lsu_wen;
            r_wdata <= lsu_wdata;
            r_wmask <= lsu_wmask;
        end else if (w_gnt_ifu) begin
            r_owner <= OWN_IFU;
            r_addr  <= ifu_addr;
            r_wen   <= 1'b0;
            r_wdata <= '0;
            r_wmask <= '0;
        end
    end

    // Route the response to its owner; writes return zero data.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ifu_resp  <= 1'b0;
            r_lsu_resp  <= 1'b0;
            r_ifu_rdata <= '0;
            r_lsu_rdata <= '0;
        end else begin
            r_ifu_resp <= w_resp & (r_owner == OWN_IFU);
            r_lsu_resp <= w_resp & (r_owner == OWN_LSU);
            if (w_resp) begin
                if (r_owner == OWN_IFU) begin
                    r_ifu_rdata <= mem_rdata;
                end else begin
                    r_lsu_rdata <= r_wen ? '0 : mem_rdata;
                end
            end
        end
    end

endmodule
